// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } uart_tx_state_t;

  // start + 8 data + parity + 2 stop
  localparam int UART_FRAME_BITS = 12;
  localparam logic [3:0] UART_LAST_BIT = 4'(UART_FRAME_BITS - 1);

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled; tick is a
// registered flag that is high exactly while the count sits at terminal.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (clear) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt == TERM) ? '0 : cnt + 1'b1;
    end
  end

  // tick is decoded from the next count so it lines up with the count itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == TERM);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: byte handshake, baud timing and datapath controls.
// Define UART_TX_HOLD_EN to add a one-byte hold register for back-to-back frames.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_valid,
  input  logic [7:0]     tx_data,
  input  logic           parity_odd,
  output logic           tx_ready,
  output logic [7:0]     dp_data,
  output logic           load,
  output logic           tx_sr_en,
  output logic           parity_sel,
  output logic           tx_sel,
  output logic           busy,
  output uart_tx_state_t state
);

  // Handshake: a byte is taken at a rising edge where tx_valid & tx_ready;
  // tx_ready is registered, and tx_valid without tx_ready has no effect.
  logic       accept;
  logic       frame_end;
  logic       tick;
  logic       baud_clear;
  logic       baud_en;
  logic [3:0] bit_cnt;

  logic       pending;
  logic       pending_next;
  logic       ready_in_frame;
  logic [7:0] next_byte;
  logic       next_parity;

  assign accept     = tx_valid & tx_ready;
  assign baud_clear = (state == LOAD);
  assign baud_en    = (state == SHIFT);
  assign frame_end  = (state == SHIFT) & tick & (bit_cnt == UART_LAST_BIT);
  assign tx_sr_en   = tick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .en    (baud_en),
    .tick  (tick)
  );

`ifdef UART_TX_HOLD_EN
  logic       hold_valid;
  logic       hold_parity;
  logic [7:0] hold_data;
  logic       hold_take;
  logic       hold_pop;

  // Any accept outside IDLE lands in the hold register, even on the frame-end edge.
  assign hold_take      = accept & (state != IDLE);
  assign hold_pop       = hold_valid & ((state == IDLE) | frame_end);
  assign pending        = hold_valid;
  assign pending_next   = hold_take | (hold_valid & ~hold_pop);
  assign ready_in_frame = ~pending_next;
  assign next_byte      = hold_valid ? hold_data : tx_data;
  assign next_parity    = hold_valid ? hold_parity : parity_odd;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      hold_parity <= 1'b0;
    end else if (hold_take) begin
      hold_valid  <= 1'b1;
      hold_data   <= tx_data;
      hold_parity <= parity_odd;
    end else if (hold_pop) begin
      hold_valid  <= 1'b0;
    end
  end
`else
  assign pending        = 1'b0;
  assign pending_next   = 1'b0;
  assign ready_in_frame = 1'b0;
  assign next_byte      = tx_data;
  assign next_parity    = parity_odd;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx_ready   <= 1'b0;
      dp_data    <= '0;
      load       <= 1'b0;
      parity_sel <= 1'b0;
      tx_sel     <= 1'b0;
      busy       <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          tx_sel <= 1'b0;
          if (pending | accept) begin
            dp_data    <= next_byte;
            parity_sel <= next_parity;
            load       <= 1'b1;
            busy       <= 1'b1;
            tx_ready   <= ready_in_frame;
            state      <= LOAD;
          end else begin
            busy     <= 1'b0;
            tx_ready <= 1'b1;
          end
        end
        LOAD: begin
          bit_cnt  <= '0;
          tx_sel   <= 1'b1;
          tx_ready <= ready_in_frame;
          state    <= SHIFT;
        end
        SHIFT: begin
          tx_ready <= ready_in_frame;
          if (frame_end) begin
            bit_cnt <= '0;
            tx_sel  <= 1'b0;
            if (pending) begin
              // The LOAD cycle doubles as the single idle-high gap between frames.
              dp_data    <= next_byte;
              parity_sel <= next_parity;
              load       <= 1'b1;
              state      <= LOAD;
            end else begin
              busy     <= 1'b0;
              tx_ready <= ~pending_next;
              state    <= IDLE;
            end
          end else if (tick) begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          tx_sel   <= 1'b0;
          busy     <= 1'b0;
          tx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: instance A at 4 clocks/bit, instance B at 2 clocks/bit,
// each driving a behavioural shift-register datapath whose line output is scored.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

`ifdef UART_TX_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  logic [11:0] exp_a_q[$];
  logic [11:0] exp_b_q[$];

  logic           a_reset, a_valid, a_odd;
  logic [7:0]     a_data;
  logic           a_ready, a_load, a_sr_en, a_par, a_tx_sel, a_busy;
  logic [7:0]     a_dp;
  uart_tx_state_t a_state;

  logic           b_reset, b_valid, b_odd;
  logic [7:0]     b_data;
  logic           b_ready, b_load, b_sr_en, b_par, b_tx_sel, b_busy;
  logic [7:0]     b_dp;
  uart_tx_state_t b_state;

  uart_tx_ctrl #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .reset(a_reset), .tx_valid(a_valid), .tx_data(a_data),
    .parity_odd(a_odd), .tx_ready(a_ready), .dp_data(a_dp), .load(a_load),
    .tx_sr_en(a_sr_en), .parity_sel(a_par), .tx_sel(a_tx_sel), .busy(a_busy),
    .state(a_state)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .reset(b_reset), .tx_valid(b_valid), .tx_data(b_data),
    .parity_odd(b_odd), .tx_ready(b_ready), .dp_data(b_dp), .load(b_load),
    .tx_sr_en(b_sr_en), .parity_sel(b_par), .tx_sel(b_tx_sel), .busy(b_busy),
    .state(b_state)
  );

  // Behavioural 12-bit transmit shift register (the datapath the controller drives).
  logic [11:0] sr_a, sr_b;
  logic        line_a, line_b;

  always @(posedge clk) begin
    if (a_load) sr_a <= {2'b11, (^a_dp) ^ a_par, a_dp, 1'b0};
    else if (a_sr_en) sr_a <= {1'b1, sr_a[11:1]};
    if (b_load) sr_b <= {2'b11, (^b_dp) ^ b_par, b_dp, 1'b0};
    else if (b_sr_en) sr_b <= {1'b1, sr_b[11:1]};
  end

  assign line_a = a_tx_sel ? sr_a[0] : 1'b1;
  assign line_b = b_tx_sel ? sr_b[0] : 1'b1;

  function automatic logic [11:0] frame_of(input logic [7:0] d, input logic odd);
    return {2'b11, (^d) ^ odd, d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard for instance A ----------------
  int          mon_bits    = 0;
  int          mon_cnt     = 0;
  int          mon_sel     = 0;
  int          frames_done = 0;
  int          since_end   = 1000;
  int          last_gap    = 1000;
  logic        mon_active  = 1'b0;
  logic [11:0] frame_buf   = '0;

  always @(negedge clk) begin
    if (a_reset === 1'b1) begin
      mon_active = 1'b0;
      mon_bits   = 0;
      since_end  = 1000;
    end else begin
      if (a_load === 1'b1) begin
        check("load_vs_sren", a_sr_en, 1'b0);
        mon_active = 1'b1;
        mon_bits   = 0;
        mon_cnt    = 0;
        mon_sel    = 0;
      end
      if (a_tx_sel !== 1'b1) begin
        since_end++;
      end else if (mon_active) begin
        if (mon_sel == 0) last_gap = since_end;
        mon_cnt++;
        mon_sel++;
        if (a_sr_en === 1'b1) begin
          check("bit_period", mon_cnt, 4);
          if (mon_bits < 12) frame_buf[mon_bits] = line_a;
          mon_bits++;
          mon_cnt = 0;
          if (mon_bits == 12) begin
            check("sel_cycles", mon_sel, 48);
            if (exp_a_q.size() == 0) check("frame_expected", 32'(exp_a_q.size()), 1);
            else check("frame", frame_buf, exp_a_q.pop_front());
            frames_done++;
            mon_active = 1'b0;
            since_end  = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int last_wait;

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_a(input logic [7:0] d, input logic odd);
    int n = 0;
    a_valid = 1'b1;
    a_data  = d;
    a_odd   = odd;
    while (a_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", a_ready, 1'b1);
    if (a_ready === 1'b1) exp_a_q.push_back(frame_of(d, odd));
    @(negedge clk);
    a_valid   = 1'b0;
    last_wait = n;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("frames_done", frames_done, target);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          cnt;
    int          busy_n, pulses, gap, bad_gap, overlap;
    logic [11:0] got;

    a_reset = 1'b1; a_valid = 1'b0; a_data = '0; a_odd = 1'b0;
    b_reset = 1'b1; b_valid = 1'b0; b_data = '0; b_odd = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_load", a_load, 1'b0);
    check("rst_sren", a_sr_en, 1'b0);
    check("rst_tx_sel", a_tx_sel, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_ready", a_ready, 1'b0);
    check("rst_parity_sel", a_par, 1'b0);
    check("rst_dp_data", a_dp, 8'h00);
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", a_ready, 1'b1);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_tx_sel !== 1'b0) cnt++;
    end
    check("idle_line_high", cnt, 0);

    // Single byte A5, even parity
    send_a(8'hA5, 1'b0);
    check("load_after_accept", a_load, 1'b1);
    check("dp_data_a5", a_dp, 8'hA5);
    check("tx_sel_in_load", a_tx_sel, 1'b0);
    check("ready_in_load", a_ready, HOLD);
    @(negedge clk);
    check("load_one_cycle", a_load, 1'b0);
    check("tx_sel_after_load", a_tx_sel, 1'b1);
    wait_frames(1);
    @(negedge clk);
    check("idle_ready", a_ready, 1'b1);
    check("idle_busy", a_busy, 1'b0);
    check("idle_tx_sel", a_tx_sel, 1'b0);
    check("idle_state", a_state, IDLE);

`ifdef UART_TX_HOLD_EN
    // Back-to-back through the hold register
    send_a(8'h01, 1'b0);
    check("b2b_load", a_load, 1'b1);
    send_a(8'hFF, 1'b0);
    check("b2b_accept_wait", last_wait, 0);
    check("b2b_hold_full", a_ready, 1'b0);
    wait_frames(3);
    check("b2b_gap", last_gap, 1);
`else
    // Busy rejection: 3C is held valid through the whole 12 frame
    send_a(8'h12, 1'b1);
    check("frame12_load", a_load, 1'b1);
    check("frame12_parity_sel", a_par, 1'b1);
    send_a(8'h3C, 1'b0);
    check("hold_off_wait", last_wait, 49);
    check("hold_off_load", a_load, 1'b1);
    check("hold_off_dp", a_dp, 8'h3C);
    wait_frames(3);
`endif

    // Reset mid-frame after the 5th shift pulse
    @(negedge clk);
    send_a(8'hC3, 1'b1);
`ifdef UART_TX_HOLD_EN
    send_a(8'h99, 1'b0);
`endif
    cnt = 0;
    while (mon_bits != 5 && cnt < 200) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("mid_frame_bits", mon_bits, 5);
    a_reset = 1'b1;
    @(negedge clk);
    check("midrst_tx_sel", a_tx_sel, 1'b0);
    check("midrst_busy", a_busy, 1'b0);
    check("midrst_sren", a_sr_en, 1'b0);
    exp_a_q.delete();
    a_reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", a_ready, 1'b1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_load !== 1'b0 || a_tx_sel !== 1'b0) cnt++;
    end
    check("midrst_no_stale_frame", cnt, 0);
    send_a(8'h55, 1'b0);
    check("after_rst_load", a_load, 1'b1);
    wait_frames(4);
    check("queue_a_empty", exp_a_q.size(), 0);

    // Instance B: 2 clocks/bit, 80 with odd parity
    @(negedge clk);
    b_valid = 1'b1; b_data = 8'h80; b_odd = 1'b1;
    cnt = 0;
    while (b_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("b_accept_ready", b_ready, 1'b1);
    exp_b_q.push_back(frame_of(8'h80, 1'b1));
    @(negedge clk);
    b_valid = 1'b0;
    check("b_load", b_load, 1'b1);
    busy_n = 0; pulses = 0; gap = 0; bad_gap = 0; overlap = 0; got = '0;
    for (int i = 0; i < 40; i++) begin
      if (b_busy === 1'b1) busy_n++;
      if (b_tx_sel === 1'b1) gap++;
      if (b_load === 1'b1 && b_sr_en === 1'b1) overlap++;
      if (b_sr_en === 1'b1) begin
        if (gap != 2) bad_gap++;
        if (pulses < 12) got[pulses] = line_b;
        pulses++;
        gap = 0;
      end
      @(negedge clk);
    end
    check("b_frame_cycles", busy_n, 25);
    check("b_pulses", pulses, 12);
    check("b_pulse_spacing", bad_gap, 0);
    check("b_load_vs_sren", overlap, 0);
    check("b_frame", got, exp_b_q.pop_front());
    check("b_idle_ready", b_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
